// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator running on the divided pixel clock.
// Counts pixels and lines over a parameterised frame. It drives registered sync,
// data-enable, active coordinates and frame/line start strobes for the pixel
// source and the TMDS encoder. Defaults describe 1280x720p60 (1650x750 total).
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        en,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        sof,
  output logic        sol
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries are held at 13 bits so a total of exactly 4096 still fits.
  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT_END    = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END    = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [12:0] h_ext;
  logic [12:0] v_ext;
  logic        h_act;
  logic        v_act;
  logic        de_next;
  logic        hs_next;
  logic        vs_next;
  logic [11:0] x_next;
  logic [11:0] y_next;
  logic        sof_next;
  logic        sol_next;

  // Pixel and line counters; the line counter only moves on the last pixel of a line.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  // Decode the current counter position into the next output values.
  always_comb begin
    h_ext    = {1'b0, h_cnt};
    v_ext    = {1'b0, v_cnt};
    h_act    = (h_ext < H_ACT_END);
    v_act    = (v_ext < V_ACT_END);
    de_next  = h_act && v_act;
    hs_next  = ((h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END)) ? HS_ON : ~HS_ON;
    vs_next  = ((v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END)) ? VS_ON : ~VS_ON;
    x_next   = de_next ? h_cnt : 12'd0;
    y_next   = de_next ? v_cnt : 12'd0;
    sof_next = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    sol_next = (h_cnt == 12'd0);
  end

  // Output registers trail the counters by one cycle and freeze with them when en is low.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      de  <= 1'b0;
      hs  <= ~HS_ON;
      vs  <= ~VS_ON;
      x   <= '0;
      y   <= '0;
      sof <= 1'b0;
      sol <= 1'b0;
    end else if (en) begin
      de  <= de_next;
      hs  <= hs_next;
      vs  <= vs_next;
      x   <= x_next;
      y   <= y_next;
      sof <= sof_next;
      sol <= sol_next;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of the raster generator. A small 14x7
// raster is instantiated with both sync polarities, next to a default 720p instance.
module tb_video_timing_gen;

  typedef struct {
    logic en;
    logic de;
    logic hs;
    logic vs;
    int   x;
    int   y;
    logic sof;
    logic sol;
  } vec_t;

  logic        clkin;
  logic        reset;
  logic        en;

  logic        hs_s, vs_s, de_s, sof_s, sol_s;
  logic [11:0] x_s, y_s;
  logic        hs_p, vs_p, de_p, sof_p, sol_p;
  logic [11:0] x_p, y_p;
  logic        hs_d, vs_d, de_d, sof_d, sol_d;
  logic [11:0] x_d, y_d;

  int n_cmp;
  int n_fail;

  vec_t tbl [17];

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1)
  ) dut_s (
    .clkin(clkin), .reset(reset), .en(en),
    .hs(hs_s), .vs(vs_s), .de(de_s), .x(x_s), .y(y_s), .sof(sof_s), .sol(sol_s)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0)
  ) dut_p (
    .clkin(clkin), .reset(reset), .en(en),
    .hs(hs_p), .vs(vs_p), .de(de_p), .x(x_p), .y(y_p), .sof(sof_p), .sol(sol_p)
  );

  video_timing_gen dut_d (
    .clkin(clkin), .reset(reset), .en(en),
    .hs(hs_d), .vs(vs_d), .de(de_d), .x(x_d), .y(y_d), .sof(sof_d), .sol(sol_d)
  );

  // Free-running pixel clock, 10 time units per cycle.
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compares the small raster (both polarities) against one expected record.
  task automatic check_small(input string tag, input vec_t e);
    check_output({tag, ".de"},  int'(de_s),  int'(e.de));
    check_output({tag, ".hs"},  int'(hs_s),  int'(e.hs));
    check_output({tag, ".vs"},  int'(vs_s),  int'(e.vs));
    check_output({tag, ".x"},   int'(x_s),   e.x);
    check_output({tag, ".y"},   int'(y_s),   e.y);
    check_output({tag, ".sof"}, int'(sof_s), int'(e.sof));
    check_output({tag, ".sol"}, int'(sol_s), int'(e.sol));
    check_output({tag, ".p.hs"}, int'(hs_p), int'(!e.hs));
    check_output({tag, ".p.vs"}, int'(vs_p), int'(!e.vs));
  endtask

  // Drives en ahead of one rising edge and samples 1 unit after it.
  task automatic apply_stimulus(input logic en_val);
    en = en_val;
    @(posedge clkin);
    #1;
  endtask

  // Holds reset across one edge, then releases it just after an edge.
  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clkin);
    #1;
    reset = 1'b0;
  endtask

  // Expected small-raster outputs after the edge that decodes enabled cycle n.
  function automatic vec_t model(input int n);
    vec_t e;
    int h, v;
    h = n % 14;
    v = (n / 14) % 7;
    e.en  = 1'b1;
    e.de  = (h < 8) && (v < 4);
    e.hs  = (h == 10) || (h == 11);
    e.vs  = (v == 5);
    e.x   = e.de ? h : 0;
    e.y   = e.de ? v : 0;
    e.sof = (n % 98) == 0;
    e.sol = (h == 0);
    return e;
  endfunction

  initial begin
    vec_t e;
    int   de_cnt;
    int   last_sof;
    int   sof_seen;
    int   found;

    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    en     = 1'b1;

    // Hand-computed first line of the small raster, plus an en=0 hold row.
    //            en    de    hs    vs    x  y  sof   sol
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6, 0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0};

    // Reset state on all instances.
    @(posedge clkin);
    #1;
    check_small("rst", '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
    check_output("rst.d.hs", int'(hs_d), 0);
    check_output("rst.d.vs", int'(vs_d), 0);
    check_output("rst.d.de", int'(de_d), 0);
    reset = 1'b0;

    // Table-driven first line of the small raster.
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(tbl[i].en);
      check_small($sformatf("tbl%0d", i), tbl[i]);
    end

    // Default raster after reset release: active edge, last active pixel, sync edges.
    pulse_reset();
    for (int k = 1; k <= 1431; k++) begin
      apply_stimulus(1'b1);
      if (k == 1) begin
        check_output("d.first.de",  int'(de_d),  1);
        check_output("d.first.sof", int'(sof_d), 1);
        check_output("d.first.sol", int'(sol_d), 1);
        check_output("d.first.x",   int'(x_d),   0);
        check_output("d.first.y",   int'(y_d),   0);
        check_output("d.first.hs",  int'(hs_d),  0);
        check_output("d.first.vs",  int'(vs_d),  0);
      end else if (k == 1280) begin
        check_output("d.e1280.de", int'(de_d), 1);
        check_output("d.e1280.x",  int'(x_d),  1279);
      end else if (k == 1281) begin
        check_output("d.e1281.de", int'(de_d), 0);
        check_output("d.e1281.x",  int'(x_d),  0);
      end else if (k == 1390) begin
        check_output("d.hs_pre", int'(hs_d), 0);
      end else if (k == 1391) begin
        check_output("d.hs_start", int'(hs_d), 1);
      end else if (k == 1430) begin
        check_output("d.hs_last", int'(hs_d), 1);
      end else if (k == 1431) begin
        check_output("d.hs_end", int'(hs_d), 0);
      end
    end

    // Two full small-raster frames against the cycle-index model.
    pulse_reset();
    de_cnt   = 0;
    last_sof = -1;
    sof_seen = 0;
    for (int n = 0; n < 196; n++) begin
      apply_stimulus(1'b1);
      e = model(n);
      check_small($sformatf("frm.n%0d", n), e);
      if (de_s) de_cnt++;
      if (sof_s) begin
        sof_seen++;
        if (last_sof >= 0) check_output("sof.period", n - last_sof, 98);
        last_sof = n;
      end
      if (n == 97 || n == 195) begin
        check_output("de.per_frame", de_cnt, 32);
        de_cnt = 0;
      end
    end
    check_output("sof.count", sof_seen, 2);

    // Enable gating: hold for 3 cycles at x=5, then resume at x=6.
    pulse_reset();
    for (int k = 1; k <= 6; k++) apply_stimulus(1'b1);
    check_output("gate.pre.x", int'(x_s), 5);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0);
      check_output($sformatf("gate.hold%0d.x", k), int'(x_s), 5);
      check_output($sformatf("gate.hold%0d.de", k), int'(de_s), 1);
    end
    apply_stimulus(1'b1);
    check_output("gate.resume.x", int'(x_s), 6);
    found = 0;
    for (int k = 11; k <= 200 && found == 0; k++) begin
      apply_stimulus(1'b1);
      if (sof_s) found = k;
    end
    check_output("gate.sof_period", found - 1, 101);

    // Mid-frame asynchronous reset at h_cnt=6, v_cnt=3.
    pulse_reset();
    for (int k = 1; k <= 48; k++) apply_stimulus(1'b1);
    check_small("mid.pre", '{1'b1, 1'b1, 1'b0, 1'b0, 5, 3, 1'b0, 1'b0});
    #2;
    reset = 1'b1;
    #1;
    check_small("mid.rst", '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
    @(posedge clkin);
    #1;
    reset = 1'b0;
    apply_stimulus(1'b1);
    check_small("mid.restart", model(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
